// File: rtl/brute_force_gen.sv
// Odometer-order brute-force candidate generator with valid/ready output.
// Optional accepted-candidate counter: define BRUTE_FORCE_GEN_COUNT_EN.
module brute_force_gen #(
    parameter int         MAX_CHARS = 16,
    parameter logic [7:0] CHAR_LO   = 8'h61,
    parameter logic [7:0] CHAR_HI   = 8'h7A,
    parameter int         STEP_W    = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [7:0]             start_char,
    input  logic [STEP_W-1:0]      increment,
    input  logic                   ready,
    output logic                   valid,
    output logic [8*MAX_CHARS-1:0] password,
    output logic [4:0]             num_chars,
    output logic                   done
`ifdef BRUTE_FORCE_GEN_COUNT_EN
    ,
    output logic [31:0]            count
`endif
);

    localparam int         PW  = 8 * MAX_CHARS;
    localparam logic [8:0] HI9 = 9'(CHAR_HI);
    localparam logic [8:0] R9  = 9'(CHAR_HI) - 9'(CHAR_LO) + 9'd1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_n;

    logic [STEP_W-1:0] stride;
    logic [PW-1:0]     nxt_pw;
    logic [4:0]        nxt_n;
    logic              exhaust;
    logic              accept;
    logic [7:0]        first_char;
    logic [STEP_W-1:0] first_stride;

    assign accept = (state == RUN) && enable && ready;

    always_comb begin
        first_char = start_char;
        if (start_char < CHAR_LO || start_char > CHAR_HI)
            first_char = CHAR_LO;
        first_stride = increment;
        if (increment == '0)
            first_stride = STEP_W'(1);
    end

    // Ripple the stride through the active characters like an odometer.
    always_comb begin
        logic       carry;
        logic [8:0] add;
        logic [8:0] sum;
        carry   = 1'b0;
        add     = '0;
        sum     = '0;
        nxt_pw  = password;
        nxt_n   = num_chars;
        exhaust = 1'b0;
        for (int i = 0; i < MAX_CHARS; i++) begin
            if (5'(i) < num_chars) begin
                add = (i == 0) ? 9'(stride) : {8'd0, carry};
                sum = {1'b0, password[8*i +: 8]} + add;
                if (sum > HI9) begin
                    nxt_pw[8*i +: 8] = 8'(sum - R9);
                    carry = 1'b1;
                end else begin
                    nxt_pw[8*i +: 8] = sum[7:0];
                    carry = 1'b0;
                end
            end
        end
        if (carry) begin
            if (num_chars < 5'(MAX_CHARS)) begin
                nxt_n = 5'(num_chars + 5'd1);
                for (int i = 0; i < MAX_CHARS; i++) begin
                    if (5'(i) == num_chars)
                        nxt_pw[8*i +: 8] = CHAR_LO;
                end
            end else begin
                exhaust = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (enable) state_n = RUN;
            RUN: begin
                if (!enable)
                    state_n = IDLE;
                else if (ready && exhaust)
                    state_n = DONE;
            end
            DONE: if (!enable) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            valid     <= 1'b0;
            done      <= 1'b0;
            password  <= '0;
            num_chars <= '0;
            stride    <= '0;
        end else begin
            state <= state_n;
            valid <= (state_n == RUN);
            done  <= (state_n == DONE);
            if (state == IDLE && enable) begin
                password  <= PW'(first_char);
                num_chars <= 5'd1;
                stride    <= first_stride;
            end else if (accept && !exhaust) begin
                password  <= nxt_pw;
                num_chars <= nxt_n;
            end
        end
    end

`ifdef BRUTE_FORCE_GEN_COUNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (state == IDLE && enable)
            count <= '0;
        else if (accept && count != 32'hFFFF_FFFF)
            count <= count + 32'd1;
    end
`endif

endmodule
